pipe_barrel_shifter: RTL and testbench

Parametrised, fully pipelined logarithmic barrel shifter. It replaces the fixed 8-bit combinational shifter in the NPC execute path. It takes one shift operation per cycle through a valid/ready handshake and carries a caller tag alongside each operation. It has log2(WIDTH) register stages with full backpressure, so it sits between issue and writeback without needing a stall controller of its own.

---
 rtl/shifter_pkg.sv | 53 +++++
 rtl/shift_stage.sv | 40 ++++
 rtl/pipe_barrel_shifter.sv | 122 ++++++++++++
 tb/tb_pipe_barrel_shifter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter: shift mode encoding and the
// decode of a mode into the per-stage datapath controls.
// Optional feature macro: PIPE_BARREL_SHIFTER_ROL_EN (enables rotate-left decode).
package shifter_pkg;

    typedef enum logic [2:0] {
        SH_SLL = 3'b000,
        SH_SRL = 3'b001,
        SH_SRA = 3'b010,
        SH_ROR = 3'b011,
        SH_ROL = 3'b100
    } shift_mode_e;

    // Per-stage controls; all zero means pass-through.
    typedef struct packed {
        logic shift;
        logic left;
        logic rotate;
        logic arith;
    } shift_ctrl_t;

    function automatic shift_ctrl_t decode_mode(input logic [2:0] mode);
        shift_ctrl_t ctrl;
        ctrl = '0;
        case (mode)
            SH_SLL: begin
                ctrl.shift = 1'b1;
                ctrl.left  = 1'b1;
            end
            SH_SRL: begin
                ctrl.shift = 1'b1;
            end
            SH_SRA: begin
                ctrl.shift = 1'b1;
                ctrl.arith = 1'b1;
            end
            SH_ROR: begin
                ctrl.shift  = 1'b1;
                ctrl.rotate = 1'b1;
            end
`ifdef PIPE_BARREL_SHIFTER_ROL_EN
            SH_ROL: begin
                ctrl.shift  = 1'b1;
                ctrl.left   = 1'b1;
                ctrl.rotate = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One logarithmic shifter stage: shifts or rotates by the constant DIST when
// enabled, otherwise passes the data through. Purely combinational.
// Optional feature macro: PIPE_BARREL_SHIFTER_ROL_EN (adds the rotate-left mux input).
module shift_stage
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIST  = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             en_i,
    input  shift_ctrl_t      ctrl_i,
    input  logic             sign_i,
    output logic [WIDTH-1:0] data_o
);

    // Select the shifted/rotated form of the operand for this stage's distance.
    always_comb begin
        data_o = data_i;
        if (en_i && ctrl_i.shift) begin
            if (ctrl_i.rotate) begin
`ifdef PIPE_BARREL_SHIFTER_ROL_EN
                if (ctrl_i.left) begin
                    data_o = {data_i[WIDTH-DIST-1:0], data_i[WIDTH-1:WIDTH-DIST]};
                end else begin
                    data_o = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
                end
`else
                data_o = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
`endif
            end else if (ctrl_i.left) begin
                data_o = {data_i[WIDTH-DIST-1:0], {DIST{1'b0}}};
            end else begin
                // Sign bit was captured at entry, so every stage fills consistently.
                data_o = {{DIST{ctrl_i.arith & sign_i}}, data_i[WIDTH-1:DIST]};
            end
        end
    end

endmodule

// File: rtl/pipe_barrel_shifter.sv
// Fully pipelined logarithmic barrel shifter with valid/ready handshake and a
// pass-through tag. Stage k applies a shift of 2^k when amt[k] is set; stages
// run LSB first. Each stage is elastic, so bubbles collapse under backpressure.
// Optional feature macro: PIPE_BARREL_SHIFTER_ROL_EN (mode 3'b100 = rotate left).
module pipe_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [2:0]               in_mode,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int unsigned SHW = $clog2(WIDTH);

    // Stage registers
    logic [SHW-1:0]   valid_q;
    logic [WIDTH-1:0] data_q [SHW];
    logic [SHW-1:0]   amt_q  [SHW];
    logic [2:0]       mode_q [SHW];
    logic             sign_q [SHW];
    logic [TAG_W-1:0] tag_q  [SHW];

    // Values presented to each stage's input
    logic             stg_valid   [SHW];
    logic [WIDTH-1:0] stg_data    [SHW];
    logic [SHW-1:0]   stg_amt     [SHW];
    logic [2:0]       stg_mode    [SHW];
    logic             stg_sign    [SHW];
    logic [TAG_W-1:0] stg_tag     [SHW];
    shift_ctrl_t      stg_ctrl    [SHW];
    logic [WIDTH-1:0] stg_shifted [SHW];

    logic [SHW-1:0] load;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign stg_valid[k] = in_valid;
            assign stg_data[k]  = in_data;
            assign stg_amt[k]   = in_amt;
            assign stg_mode[k]  = in_mode;
            assign stg_sign[k]  = in_data[WIDTH-1];
            assign stg_tag[k]   = in_tag;
        end else begin : g_next
            assign stg_valid[k] = valid_q[k-1];
            assign stg_data[k]  = data_q[k-1];
            assign stg_amt[k]   = amt_q[k-1];
            assign stg_mode[k]  = mode_q[k-1];
            assign stg_sign[k]  = sign_q[k-1];
            assign stg_tag[k]   = tag_q[k-1];
        end

        assign stg_ctrl[k] = decode_mode(stg_mode[k]);

        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (2 ** k)
        ) u_shift_stage (
            .data_i (stg_data[k]),
            .en_i   (stg_amt[k][k]),
            .ctrl_i (stg_ctrl[k]),
            .sign_i (stg_sign[k]),
            .data_o (stg_shifted[k])
        );
    end

    // Stage k may load unless it and every stage after it are full with the output stalled.
    always_comb begin
        for (int k = 0; k < SHW; k++) begin
            load[k] = out_ready;
            for (int j = k; j < SHW; j++) begin
                if (!valid_q[j]) begin
                    load[k] = 1'b1;
                end
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = valid_q[SHW-1];
    assign out_data  = data_q[SHW-1];
    assign out_tag   = tag_q[SHW-1];

    // Advance the pipeline; payload registers only update when a valid op moves in.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= '0;
                amt_q[k]  <= '0;
                mode_q[k] <= '0;
                sign_q[k] <= 1'b0;
                tag_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < SHW; k++) begin
                if (load[k]) begin
                    valid_q[k] <= stg_valid[k];
                    if (stg_valid[k]) begin
                        data_q[k] <= stg_shifted[k];
                        amt_q[k]  <= stg_amt[k];
                        mode_q[k] <= stg_mode[k];
                        sign_q[k] <= stg_sign[k];
                        tag_q[k]  <= stg_tag[k];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Self-checking bench for pipe_barrel_shifter (WIDTH=32, TAG_W=4).
// Honours PIPE_BARREL_SHIFTER_ROL_EN for the expected rotate-left behaviour.
module tb_pipe_barrel_shifter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned SHW   = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_data = '0;
    logic [4:0]       in_amt = '0;
    logic [2:0]       in_mode = '0;
    logic [3:0]       in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_data;
    logic [3:0]       out_tag;

    int errors = 0;
    int checks = 0;

    pipe_barrel_shifter #(
        .WIDTH (WIDTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour written directly from the mode definitions.
    function automatic logic [31:0] model(input logic [31:0] d, input int a, input logic [2:0] m);
        logic [63:0]        dd;
        logic [63:0]        tmp;
        logic signed [31:0] s;
        dd = {d, d};
        s  = d;
        case (m)
            3'd0: return d << a;
            3'd1: return d >> a;
            3'd2: return s >>> a;
            3'd3: begin
                tmp = dd >> a;
                return tmp[31:0];
            end
`ifdef PIPE_BARREL_SHIFTER_ROL_EN
            3'd4: begin
                tmp = dd << a;
                return tmp[63:32];
            end
`endif
            default: return d;
        endcase
    endfunction

    typedef struct {
        logic [31:0] d;
        logic [3:0]  t;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    bit          stalled = 1'b0;
    logic [31:0] hold_d;
    logic [3:0]  hold_t;

    // Scoreboard: record accepts, compare every retire, watch stall stability.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stalled = 1'b0;
        end else begin
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL no_stale: out_valid=1 with tag %h, expected no result", out_tag);
                end else if (out_ready) begin
                    e = exp_q.pop_front();
                    check("model_data", out_data, e.d);
                    check("model_tag", 32'(out_tag), 32'(e.t));
                end
            end
            if (out_valid && !out_ready) begin
                if (stalled) begin
                    check("stall_data_stable", out_data, hold_d);
                    check("stall_tag_stable", 32'(out_tag), 32'(hold_t));
                end
                stalled = 1'b1;
                hold_d  = out_data;
                hold_t  = out_tag;
            end else begin
                stalled = 1'b0;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back('{d: model(in_data, int'(in_amt), in_mode), t: in_tag});
            end
        end
    end

    // Single operation against a hand-computed literal, including latency in edges.
    task automatic run_op(input string name, input logic [31:0] d, input logic [4:0] a,
                          input logic [2:0] m, input logic [3:0] t, input logic [31:0] exp);
        int lat;
        bit ok;
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_data   = d;
        in_amt    = a;
        in_mode   = m;
        in_tag    = t;
        out_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            check({name, "_accept_timeout"}, 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        ok  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        check({name, "_out_valid_seen"}, 32'(ok), 32'd1);
        check({name, "_latency"}, 32'(lat), 32'(SHW));
        check({name, "_data"}, out_data, exp);
        check({name, "_tag"}, 32'(out_tag), 32'(t));
        @(posedge clk);
    endtask

    // Eight back-to-back ops with out_ready low in cycles lo..hi of the burst.
    task automatic burst(input int lo, input int hi, input logic [31:0] base);
        int sent;
        int recv;
        sent = 0;
        recv = 0;
        for (int c = 0; c < 60 && recv < 8; c++) begin
            @(posedge clk);
            #1;
            out_ready = !(c >= lo && c <= hi);
            in_valid  = (sent < 8);
            in_data   = base ^ (32'(sent) * 32'h0101_0101);
            in_amt    = 5'(sent * 3 + 1);
            in_mode   = 3'(sent % 4);
            in_tag    = 4'(sent);
            @(negedge clk);
            if (c == 4) check("burst_in_ready_not_full", 32'(in_ready), 32'd1);
            if (c == 5) check("burst_in_ready_full", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                check("burst_tag_order", 32'(out_tag), 32'(recv));
                recv++;
            end
            if (in_valid && in_ready) sent++;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("burst_count", 32'(recv), 32'd8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", out_data, 32'd0);
        check("reset_out_tag", 32'(out_tag), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Basic shifts and extremes
        run_op("sll_f1_4", 32'h0000_00F1, 5'd4, 3'b000, 4'd3, 32'h0000_0F10);
        run_op("sra_31", 32'h8000_0000, 5'd31, 3'b010, 4'd1, 32'hFFFF_FFFF);
        run_op("srl_31", 32'h8000_0000, 5'd31, 3'b001, 4'd2, 32'h0000_0001);
        run_op("sll_31", 32'hFFFF_FFFF, 5'd31, 3'b000, 4'd4, 32'h8000_0000);
        run_op("sra_pos_7", 32'h4000_0000, 5'd7, 3'b010, 4'd5, 32'h0080_0000);

        // Rotates
        run_op("ror_1", 32'h0000_0001, 5'd1, 3'b011, 4'd6, 32'h8000_0000);
        run_op("ror_12", 32'h1234_5678, 5'd12, 3'b011, 4'd7, 32'h6781_2345);
`ifdef PIPE_BARREL_SHIFTER_ROL_EN
        run_op("rol_1", 32'h8000_0000, 5'd1, 3'b100, 4'd8, 32'h0000_0001);
`else
        run_op("rol_1", 32'h8000_0000, 5'd1, 3'b100, 4'd8, 32'h8000_0000);
`endif

        // Amount zero in every mode, and pass-through mode with non-zero amount
        for (int m = 0; m < 8; m++) begin
            run_op("amt0", 32'hDEAD_BEEF, 5'd0, 3'(m), 4'(m), 32'hDEAD_BEEF);
        end
        run_op("mode7_amt7", 32'hDEAD_BEEF, 5'd7, 3'b111, 4'd9, 32'hDEAD_BEEF);

        // Backpressure
        burst(3, 5, 32'hA5A5_0F0F);
        burst(5, 8, 32'h1357_9BDF);

        // Reset with three ops in flight, plus one offered during reset
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hCAFE_0000 + 32'(i);
            in_amt   = 5'(i + 1);
            in_mode  = 3'b000;
            in_tag   = 4'(9 + i);
            @(posedge clk);
            #1;
        end
        in_tag = 4'd12;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_mid_no_stale", 32'(out_valid), 32'd0);
        end

        // Pipeline still works after the mid-flight reset
        run_op("post_rst_srl", 32'hF000_000F, 5'd4, 3'b001, 4'd10, 32'h0F00_0000);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
